dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port word data memory between the pipeline load/store unit (port 0) and a DMA/debug port (port 1).
//  Round-robin arbitration; valid/ready requests; per-port registered responses.
//  Byte/halfword stores become a read-modify-write, since memory writes whole words only.
//  Sits between the LSU/DMA and data_memory; memory read is combinational, write lands on posedge clk.
// PARAMETERS
//  MEM_WORDS  1024  memory depth in 32-bit words; byte addr >= MEM_WORDS*4 is out of range
//  MEM_AW     10    log2(MEM_WORDS); width of word index carried on mem_a
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   2   per-port request valid; [0]=LSU, [1]=DMA
//  req_ready    out  2   per-port accept; transfer when valid&&ready
//  req_we0/1    in   1   1=store, 0=load
//  req_size0/1  in   2   00 byte, 01 half, 10 word, 11 reserved (error)
//  req_addr0/1  in   32  byte address
//  req_wdata0/1 in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid   out  2   one-cycle response pulse to owning port
//  resp_rdata   out  32  full aligned word read (loads); 0 for stores/errors
//  resp_err     out  1   misaligned, out-of-range or reserved size; valid with resp_valid
//  mem_we       out  1   to memory WE
//  mem_a        out  32  word index {zeros, addr[MEM_AW+1:2]}
//  mem_wd       out  32  to memory WD
//  mem_rd       in   32  combinational read data from memory
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0, rr pointer=1.
//  Reset mid-operation aborts: pending RMW write dropped; no mem_we in the cycle after rst.
//  FSM: IDLE -> EXEC -> (RMW ->) IDLE.
//  IDLE: grant = sole valid port; if both valid, the port not last granted (after reset: port 0).
//  req_ready[g]=1 only in IDLE, only for granted port; combinational from req_valid.
//  Requester holds valid and fields stable until ready. On accept, latch we/size/addr/wdata/owner; ptr=owner.
//  Error check on accept: half with addr[0]!=0, word with addr[1:0]!=0, size 11, or out of range.
//  Error: skip EXEC; next cycle resp_valid[owner]=1, resp_err=1, no mem access.
//  EXEC (accept cycle + 1): mem_a driven from latched addr.
//   Load: resp_rdata<=mem_rd; resp_valid[owner] next cycle; -> IDLE.
//   Word store: mem_we=1, mem_wd=wdata; resp next cycle; -> IDLE.
//   Byte/half store: capture mem_rd into merge reg; -> RMW.
//  RMW: mem_we=1; mem_wd = merge word with lane addr[1:0] (byte) or addr[1] (half) replaced; resp next cycle; -> IDLE.
//  Latency accept->resp_valid: load/word store 2, sub-word store 3, error 1.
//  resp_valid cycle is an IDLE cycle: a new request may be accepted in it (back-to-back).
//  Max one outstanding transaction; mem_we high for at most one cycle per store.
// STRUCTURE
//  Package dmem_pkg: size encodings (SZ_B/SZ_H/SZ_W), state enum, lane-merge function.
//  Sub-module dmem_rr_arb: 2-way round-robin grant + pointer, instantiated once.
//  Top holds FSM, request latch, merge reg, response regs.
// TESTING
//  Bench memory model: combinational read, posedge write, word 7 preset 0x00F0F000.
//  1 LSU load addr 0x1C (word 7) -> mem_a=7; resp_valid[0] 2 cycles after accept; rdata 0x00F0F000; err=0.
//  2 LSU sb addr 0x1D, wdata 0xAB -> one mem_we pulse at accept+2; word 7 = 0x00F0AB00; resp at accept+3.
//  3 Both ports valid from reset, word loads -> grants port0, port1, port0 alternating; one accept per 2 cycles.
//  4 DMA sw addr 0x22 -> no mem_we; resp_valid[1] + resp_err at accept+1. Same for lw addr 0x1000.
//  5 rst asserted in RMW cycle of sh addr 0x1E -> no mem_we afterwards; word 7 unchanged; outputs reset.
//  6 Word store then immediate load same addr on port 0 -> second accept in resp cycle; load returns stored data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Size encodings, FSM states, latched request bundle, lane merge.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RMW
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        owner;
  } req_t;

  // Replace the addressed byte or halfword lane of a memory word.
  function automatic logic [31:0] lane_merge(
    input logic [31:0] word,
    input logic [31:0] wd,
    input logic [1:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = word;
    if (size == SZ_B)
      r[{off, 3'b000} +: 8] = wd[7:0];
    else if (size == SZ_H)
      r[{off[1], 4'b0000} +: 16] = wd[15:0];
    return r;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant for the data-memory arbiter.
// Pointer remembers the last granted port; ties go to the other one.
module dmem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= 1'b1;
    else if (upd)
      ptr_q <= gnt[1];
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
      default: gnt = req;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates LSU and DMA access to the single-port data memory.
// Sub-word stores run as read-modify-write over two cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int MEM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic        req_we0,
  input  logic        req_we1,
  input  logic [1:0]  req_size0,
  input  logic [1:0]  req_size1,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [32:0] LIMIT =
    33'(MEM_WORDS) * 33'd4;

  state_t            state_q;
  state_t            state_d;
  req_t              sel;
  req_t              cur_q;
  logic [31:0]       sel_addr;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0]       merge_q;
  logic [1:0]        gnt;
  logic [1:0]        own_oh;
  logic              accept;
  logic              sel_err;
  logic              sub_st;

  dmem_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .upd (accept),
    .gnt (gnt)
  );

  assign req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel.owner = gnt[1];
    sel.we    = gnt[1] ? req_we1    : req_we0;
    sel.size  = gnt[1] ? req_size1  : req_size0;
    sel.wdata = gnt[1] ? req_wdata1 : req_wdata0;
    sel_addr  = gnt[1] ? req_addr1  : req_addr0;
  end

  assign sel_err =
    (sel.size == SZ_R) ||
    (sel.size == SZ_H && sel_addr[0]) ||
    (sel.size == SZ_W && sel_addr[1:0] != 2'b00) ||
    ({1'b0, sel_addr} >= LIMIT);

  assign own_oh = cur_q.owner ? 2'b10 : 2'b01;
  assign sub_st = cur_q.we && cur_q.size != SZ_W;
  assign mem_a  = {{(32-MEM_AW){1'b0}},
                   addr_q[MEM_AW+1:2]};

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q      <= '0;
      addr_q     <= '0;
      merge_q    <= '0;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 2'b00;
      unique case (state_q)
        IDLE: if (accept) begin
          cur_q  <= sel;
          addr_q <= sel_addr[MEM_AW+1:0];
          if (sel_err) begin
            resp_valid <= sel.owner ? 2'b10 : 2'b01;
            resp_rdata <= '0;
            resp_err   <= 1'b1;
          end
        end
        EXEC: begin
          if (sub_st) begin
            merge_q <= mem_rd;
          end else begin
            resp_valid <= own_oh;
            resp_rdata <= cur_q.we ? '0 : mem_rd;
            resp_err   <= 1'b0;
          end
        end
        RMW: begin
          resp_valid <= own_oh;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Writes are gated by rst so an aborted store never lands.
  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    mem_wd  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept && !sel_err)
          state_d = EXEC;
      end
      EXEC: begin
        if (sub_st) begin
          state_d = RMW;
        end else begin
          state_d = IDLE;
          mem_we  = cur_q.we && !rst;
          mem_wd  = cur_q.we ? cur_q.wdata : '0;
        end
      end
      RMW: begin
        state_d = IDLE;
        mem_we  = !rst;
        mem_wd  = lane_merge(merge_q, cur_q.wdata,
                             cur_q.size, addr_q[1:0]);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a word-array memory model.
// Expected responses are queued at accept and checked on resp_valid.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [1:0]  sz0 = 2'b0, sz1 = 2'b0;
  logic [31:0] a0 = '0, a1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  assign req_valid = {v1, v0};
  assign mem_rd    = mem[mem_a[9:0]];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_we) mem[mem_a[9:0]] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we0    (we0),
    .req_we1    (we1),
    .req_size0  (sz0),
    .req_size1  (sz1),
    .req_addr0  (a0),
    .req_addr1  (a1),
    .req_wdata0 (wd0),
    .req_wdata1 (wd1),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
    logic        st;
    int          widx;
    logic [31:0] nw;
  } exp_t;

  typedef struct {
    int          cyc;
    int          widx;
    logic [31:0] wd;
  } wexp_t;

  typedef struct {
    int cyc;
    int widx;
  } aexp_t;

  typedef struct {
    int port;
    int cyc;
  } acc_t;

  exp_t  exp_q[$];
  wexp_t we_q[$];
  aexp_t a_q[$];
  acc_t  acc_log[$];

  int checks = 0;
  int errors = 0;
  int last_g = 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic bit m_err(input logic [1:0] sz,
                               input logic [31:0] a);
    return (sz == 2'd3) ||
           (sz == 2'd1 && (a % 2) != 0) ||
           (sz == 2'd2 && (a % 4) != 0) ||
           (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old,
                                          input logic [1:0] sz,
                                          input logic [31:0] a,
                                          input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (sz == 2'd2) return d;
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 4);
      m  = 32'hFF << sh;
    end else begin
      sh = 16 * int'((a / 2) % 2);
      m  = 32'hFFFF << sh;
    end
    return (old & ~m) | ((d << sh) & m);
  endfunction

  // Monitor: readiness, memory strobes, responses, accepts.
  always @(negedge clk) begin
    logic [1:0]  er;
    logic [1:0]  sz;
    logic [31:0] a, d;
    logic        w;
    bit          busy;
    exp_t        e;
    if (rst) begin
      exp_q.delete();
      we_q.delete();
      a_q.delete();
      last_g = 1;
      chk("mem_we_in_reset", mem_we, 0);
    end else begin
      busy = exp_q.size() != 0 && exp_q[0].due != cyc;
      er = 2'b00;
      if (!busy) begin
        if (req_valid == 2'b11)
          er = (last_g == 1) ? 2'b01 : 2'b10;
        else
          er = req_valid;
      end
      chk("req_ready", req_ready, er);
      if (we_q.size() != 0 && we_q[0].cyc == cyc) begin
        chk("mem_we", mem_we, 1);
        chk("mem_a_wr", mem_a, we_q[0].widx);
        chk("mem_wd", mem_wd, we_q[0].wd);
        void'(we_q.pop_front());
      end else if (mem_we) begin
        chk("mem_we_spurious", mem_we, 0);
      end
      if (a_q.size() != 0 && a_q[0].cyc == cyc) begin
        chk("mem_a_exec", mem_a, a_q[0].widx);
        void'(a_q.pop_front());
      end
      if (resp_valid != 0 ||
          (exp_q.size() != 0 && cyc >= exp_q[0].due)) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_valid", resp_valid,
              (e.port == 1) ? 2'b10 : 2'b01);
          chk("resp_cycle", cyc, e.due);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
          if (e.st) ref_mem[e.widx] = e.nw;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          w  = p[0] ? we1 : we0;
          sz = p[0] ? sz1 : sz0;
          a  = p[0] ? a1  : a0;
          d  = p[0] ? wd1 : wd0;
          e.port  = p;
          e.err   = m_err(sz, a);
          e.st    = 1'b0;
          e.widx  = int'(a >> 2);
          e.rdata = '0;
          e.nw    = '0;
          if (e.err) begin
            e.due = cyc + 1;
          end else begin
            a_q.push_back('{cyc + 1, e.widx});
            if (!w) begin
              e.rdata = ref_mem[e.widx];
              e.due   = cyc + 2;
            end else begin
              e.st  = 1'b1;
              e.nw  = m_store(ref_mem[e.widx], sz, a, d);
              e.due = (sz == 2'd2) ? cyc + 2 : cyc + 3;
              we_q.push_back('{e.due - 1, e.widx, e.nw});
            end
          end
          exp_q.push_back(e);
          acc_log.push_back('{p, cyc});
          last_g = p;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input int p, input logic w,
                       input logic [1:0] sz,
                       input logic [31:0] a,
                       input logic [31:0] d);
    int  n;
    bit  ok;
    if (p == 0) begin
      we0 = w; sz0 = sz; a0 = a; wd0 = d; v0 = 1'b1;
    end else begin
      we1 = w; sz1 = sz; a1 = a; wd1 = d; v1 = 1'b1;
    end
    n  = 0;
    ok = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (req_ready[p]) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: port %0d got no ready, required ready within 60 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) v0 = 1'b0;
    else        v1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0",
               exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
  endtask

  task automatic rand_port(input int p, input int n);
    int          k;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 3);
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
      sz = ($urandom_range(0, 9) == 0) ? 2'd3
           : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0)
        a = 32'h1000 + 32'($urandom_range(0, 255));
      issue(p, 1'($urandom_range(0, 1)), sz, a, $urandom);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[7]     = 32'h00F0F000;
    ref_mem[7] = 32'h00F0F000;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;

    // Aligned load of the preset word.
    issue(0, 1'b0, 2'b10, 32'h1C, 32'h0);
    wait_idle();

    // Byte store through read-modify-write.
    issue(0, 1'b1, 2'b00, 32'h1D, 32'hAB);
    wait_idle();
    chk("t2_word7", mem[7], 32'h00F0AB00);

    // Error responses: misaligned word, out of range.
    issue(1, 1'b1, 2'b10, 32'h22, 32'h12345678);
    wait_idle();
    issue(1, 1'b0, 2'b10, 32'h1000, 32'h0);
    wait_idle();

    // Store then load back-to-back on the same port.
    acc_log.delete();
    issue(0, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D);
    issue(0, 1'b0, 2'b10, 32'h40, 32'h0);
    wait_idle();
    chk("t6_accepts", acc_log.size(), 2);
    if (acc_log.size() == 2)
      chk("t6_gap", acc_log[1].cyc - acc_log[0].cyc, 2);
    chk("t6_word16", mem[16], 32'hCAFEF00D);

    // Reset during the RMW write cycle of a halfword store.
    issue(0, 1'b1, 2'b01, 32'h1E, 32'h1234);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    chk("t5_word7", mem[7], 32'h00F0AB00);
    @(posedge clk);
    #1;

    // Both ports contending straight out of reset.
    acc_log.delete();
    fork
      begin
        repeat (3)
          issue(0, 1'b0, 2'b10,
                32'(4 * $urandom_range(0, 15)), 32'h0);
      end
      begin
        repeat (3)
          issue(1, 1'b0, 2'b10,
                32'(4 * $urandom_range(0, 15)), 32'h0);
      end
    join
    wait_idle();
    chk("t3_accepts", acc_log.size(), 6);
    for (int i = 0; i < acc_log.size(); i++) begin
      chk("t3_port", acc_log[i].port, i % 2);
      if (i > 0)
        chk("t3_gap", acc_log[i].cyc - acc_log[i-1].cyc, 2);
    end

    // Random mixed traffic on both ports.
    fork
      rand_port(0, 80);
      rand_port(1, 80);
    join
    wait_idle();
    for (int i = 0; i < 16; i++)
      chk("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
